add64_sequencer: RTL and testbench
==================================

ADD64_SEQUENCER -- requirements
Module: add64_sequencer

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have the port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-003 The block SHALL have the port start, input, 1 bit: operation request, sampled on the rising edge of clk.
REQ-004 The block SHALL have the port A, input, 64 bits: first operand, sampled only when start is accepted.
REQ-005 The block SHALL have the port B, input, 64 bits: second operand, sampled only when start is accepted.
REQ-006 The block SHALL have the port Cin, input, 1 bit: carry-in, sampled only when start is accepted.
REQ-007 The block SHALL have the port add_a, output, 16 bits: operand A word driven to the external 16-bit adder.
REQ-008 The block SHALL have the port add_b, output, 16 bits: operand B word driven to the external 16-bit adder.
REQ-009 The block SHALL have the port add_cin, output, 1 bit: carry-in driven to the external 16-bit adder.
REQ-010 The block SHALL have the port add_sum, input, 16 bits: Sum returned combinationally by the external adder in the same cycle.
REQ-011 The block SHALL have the port add_cout, input, 1 bit: Cout returned combinationally by the external adder in the same cycle.
REQ-012 The block SHALL have the port Sum, output, 64 bits: result.
REQ-013 The block SHALL have the port Cout, output, 1 bit: final carry-out.
REQ-014 The block SHALL have the port busy, output, 1 bit: high while an operation is in progress (RUN or DONE).
REQ-015 The block SHALL have the port done, output, 1 bit: single-cycle pulse marking Sum/Cout valid.

Function
REQ-016 The FSM SHALL have exactly the states IDLE, RUN and DONE, plus a 2-bit word index idx.
REQ-017 In IDLE, when start=1 at a rising edge, the block SHALL latch A, B and Cin, clear idx to 0, and enter RUN; in all other states start SHALL be ignored.
REQ-018 In RUN, the block SHALL drive add_a = A_reg[16*idx+15:16*idx] and add_b = B_reg[16*idx+15:16*idx].
REQ-019 In RUN, add_cin SHALL be Cin_reg when idx=0 and the registered carry from the previous word otherwise.
REQ-020 At each rising edge in RUN, the block SHALL write add_sum into Sum[16*idx+15:16*idx], register add_cout as the carry, and increment idx.
REQ-021 After the edge that completes idx=3, the block SHALL enter DONE, with Cout equal to the registered carry of word 3.
REQ-022 In DONE, done SHALL be 1 for exactly one cycle, and the next state SHALL be IDLE unconditionally.
REQ-023 Latency SHALL be as follows: done is high in the cycle after the 4th rising edge following the accepting edge; with start held high continuously, the minimum start-to-start period is 6 cycles.
REQ-024 In IDLE and DONE, add_a, add_b and add_cin SHALL be 0.
REQ-025 Sum and Cout SHALL be valid when done=1 and SHALL hold their value until the next accepted start; Sum bits may change during RUN.
REQ-026 Arithmetic SHALL be modulo 2^64, and Cout SHALL be bit 64 of A+B+Cin; no overflow flag is provided.
REQ-027 busy SHALL be 1 in RUN and DONE and 0 in IDLE.

Reset
REQ-028 When rst_n=0, regardless of clk, the block SHALL set the state to IDLE, idx to 0, and every output (Sum, Cout, busy, done, add_a, add_b, add_cin) and every internal register to 0.
REQ-029 A reset asserted mid-operation SHALL abort the operation with no done pulse.
REQ-030 The first start after rst_n is released SHALL be accepted normally.

Verification
REQ-031 The bench SHALL cover this case: A=0x0000_0000_0000_FFFF, B=0x1, Cin=0 -> Sum=0x0000_0000_0001_0000, Cout=0, with done exactly 4 edges after acceptance.
REQ-032 The bench SHALL cover this case: A=0xFFFF_FFFF_FFFF_FFFF, B=0, Cin=1 -> Sum=0, Cout=1 (carry ripples through all 4 words).
REQ-033 The bench SHALL cover this case: A=0x1234_5678_9ABC_DEF0, B=0x0FED_CBA9_8765_4321, Cin=0 -> Sum=0x2222_2222_2222_2211, Cout=0, with add_cin sequence 0,1,1,1.
REQ-034 The bench SHALL cover this case: start pulsed again in RUN (idx=1) with different operands -> ignored; the first result is unchanged and there is a single done pulse.
REQ-035 The bench SHALL cover this case: rst_n=0 during RUN idx=2 -> busy=0, Sum=0 and no done pulse; a new start after release -> correct result.
REQ-036 The bench SHALL cover this case: start held at 1 for 20 cycles -> done pulses every 6 cycles and Sum matches a reference model each time.

Source files
------------

// File: rtl/add64_sequencer.sv
// Purpose : 64-bit add A+B+Cin done as four 16-bit words on a shared external 16-bit adder.
// Latency : accept edge, then 4 word edges; done is high in the following cycle. Start-to-start is 6 cycles minimum.
// Backpres: no queueing; start is only accepted in IDLE and ignored while busy.
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   start, A, B, Cin    request and operands (sampled on the accepting edge only)
//   add_a/add_b/add_cin word operands driven to the external adder (0 outside RUN)
//   add_sum/add_cout    combinational result returned by the external adder
//   Sum, Cout           64-bit result and final carry, valid at done and held until next accept
//   busy, done          busy in RUN/DONE; done is a one-cycle pulse in DONE
module add64_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [63:0] A,
  input  logic [63:0] B,
  input  logic        Cin,
  output logic [15:0] add_a,
  output logic [15:0] add_b,
  output logic        add_cin,
  input  logic [15:0] add_sum,
  input  logic        add_cout,
  output logic [63:0] Sum,
  output logic        Cout,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [1:0]  idx;
  logic [63:0] a_reg;
  logic [63:0] b_reg;
  logic        cin_reg;
  logic        carry;
  logic [63:0] sum_reg;
  logic        cout_reg;

  // Bit offset of the current 16-bit word.
  logic [5:0]  word_lsb;
  assign word_lsb = {idx, 4'd0};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      idx      <= 2'd0;
      a_reg    <= 64'd0;
      b_reg    <= 64'd0;
      cin_reg  <= 1'b0;
      carry    <= 1'b0;
      sum_reg  <= 64'd0;
      cout_reg <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            a_reg   <= A;
            b_reg   <= B;
            cin_reg <= Cin;
            idx     <= 2'd0;
          end
        end
        RUN: begin
          sum_reg[word_lsb +: 16] <= add_sum;
          carry                   <= add_cout;
          idx                     <= idx + 2'd1;
          // Cout is captured only from the top word so it stays stable
          // from done until the next accepted start.
          if (idx == 2'd3) begin
            cout_reg <= add_cout;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    add_a     = 16'd0;
    add_b     = 16'd0;
    add_cin   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        add_a   = a_reg[word_lsb +: 16];
        add_b   = b_reg[word_lsb +: 16];
        add_cin = (idx == 2'd0) ? cin_reg : carry;
        if (idx == 2'd3) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign Sum  = sum_reg;
  assign Cout = cout_reg;
  assign busy = (state == RUN) || (state == DONE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_add64_sequencer.sv
// Purpose : directed bench for add64_sequencer with an external 16-bit adder model.
// Latency : inputs driven and outputs sampled on the falling edge of clk.
// Backpres: n/a.
module tb_add64_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [63:0] A;
  logic [63:0] B;
  logic        Cin;
  logic [15:0] add_a;
  logic [15:0] add_b;
  logic        add_cin;
  logic [15:0] add_sum;
  logic        add_cout;
  logic [63:0] Sum;
  logic        Cout;
  logic        busy;
  logic        done;

  int n_vec;
  int n_err;
  int done_cnt;

  add64_sequencer dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .A        (A),
    .B        (B),
    .Cin      (Cin),
    .add_a    (add_a),
    .add_b    (add_b),
    .add_cin  (add_cin),
    .add_sum  (add_sum),
    .add_cout (add_cout),
    .Sum      (Sum),
    .Cout     (Cout),
    .busy     (busy),
    .done     (done)
  );

  // External combinational 16-bit adder.
  logic [16:0] adder_res;
  assign adder_res = {1'b0, add_a} + {1'b0, add_b} + {16'd0, add_cin};
  assign add_sum   = adder_res[15:0];
  assign add_cout  = adder_res[16];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
  end

  task automatic chk_val(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One full operation from an idle DUT: checks the add_cin sequence,
  // done timing, result and a single done pulse.
  task automatic do_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                       input logic ci, input logic [63:0] exp_sum, input logic exp_cout,
                       input logic [3:0] exp_cins);
    logic [3:0] cins;
    int         d0;
    d0 = done_cnt;
    @(negedge clk);
    start = 1'b1; A = a; B = b; Cin = ci;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cins[k] = add_cin;
      if (k < 3) @(negedge clk);
    end
    chk_val({tag, "_busy_run"}, busy, 1);
    chk_val({tag, "_done_early"}, done_cnt - d0, 0);
    @(negedge clk);
    chk_val({tag, "_done"}, done, 1);
    chk_val({tag, "_sum"}, Sum, exp_sum);
    chk_val({tag, "_cout"}, Cout, exp_cout);
    chk_val({tag, "_cins"}, cins, exp_cins);
    @(negedge clk);
    chk_val({tag, "_done_drop"}, done, 0);
    chk_val({tag, "_idle"}, busy, 0);
    chk_val({tag, "_sum_hold"}, Sum, exp_sum);
    chk_val({tag, "_pulses"}, done_cnt - d0, 1);
  endtask

  logic [63:0] ta [4];
  logic [63:0] tb [4];
  logic        tc [4];

  initial begin
    int          d0;
    int          k;
    logic [64:0] ref_res;

    n_vec = 0; n_err = 0; done_cnt = 0;
    rst_n = 1'b0; start = 1'b0; A = 64'd0; B = 64'd0; Cin = 1'b0;

    // Reset state
    #12;
    chk_val("rst_sum", Sum, 0);
    chk_val("rst_flags", {Cout, busy, done, add_cin}, 0);
    chk_val("rst_add", {add_a, add_b}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors
    do_op("w0carry", 64'h0000_0000_0000_FFFF, 64'h1, 1'b0,
          64'h0000_0000_0001_0000, 1'b0, 4'b0010);
    do_op("ripple", 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1,
          64'h0, 1'b1, 4'b1111);
    do_op("mixed", 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0,
          64'h2222_2222_2222_2211, 1'b0, 4'b1110);
    do_op("topcarry", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0001, 1'b1,
          64'h0000_0000_0000_0002, 1'b1, 4'b0001);

    // Start pulsed again in RUN at idx=1: ignored.
    d0 = done_cnt;
    @(negedge clk);
    start = 1'b1; A = 64'h1234_5678_9ABC_DEF0; B = 64'h0FED_CBA9_8765_4321; Cin = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk_val("rerun_add_a_idx1", add_a, 16'h9ABC);
    start = 1'b1; A = 64'hFFFF_FFFF_FFFF_FFFF; B = 64'h0; Cin = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk_val("rerun_done", done, 1);
    chk_val("rerun_sum", {Cout, Sum}, {1'b0, 64'h2222_2222_2222_2211});
    repeat (6) @(negedge clk);
    chk_val("rerun_pulses", done_cnt - d0, 1);
    chk_val("rerun_idle", busy, 0);

    // Reset during RUN at idx=2: abort with no done.
    d0 = done_cnt;
    @(negedge clk);
    start = 1'b1; A = 64'h1234_5678_9ABC_DEF0; B = 64'h0FED_CBA9_8765_4321; Cin = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk_val("abort_partial", Sum[31:0], 32'h2222_2211);
    #2 rst_n = 1'b0;
    #1;
    chk_val("abort_busy", busy, 0);
    chk_val("abort_sum", Sum, 0);
    chk_val("abort_outs", {Cout, done, add_a, add_b, add_cin}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk_val("abort_nodone", done_cnt - d0, 0);
    do_op("after_abort", 64'h0000_0000_0000_FFFF, 64'h1, 1'b0,
          64'h0000_0000_0001_0000, 1'b0, 4'b0010);

    // Start held for 20 cycles: accepts every 6 cycles.
    ta[0] = 64'h0000_0000_FFFF_FFFF; tb[0] = 64'h0000_0000_0000_0001; tc[0] = 1'b0;
    ta[1] = 64'hDEAD_BEEF_0000_1111; tb[1] = 64'h2152_4110_FFFF_EEEE; tc[1] = 1'b1;
    ta[2] = 64'h0123_4567_89AB_CDEF; tb[2] = 64'hFEDC_BA98_7654_3210; tc[2] = 1'b0;
    ta[3] = 64'h7FFF_0000_8000_FFFF; tb[3] = 64'h8001_FFFF_8000_0000; tc[3] = 1'b0;
    k = 0;
    for (int c = 0; c < 26; c++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (k < 4) begin
          ref_res = {1'b0, ta[k]} + {1'b0, tb[k]} + {64'd0, tc[k]};
          chk_val($sformatf("stream%0d_res", k), {Cout, Sum}, ref_res);
          chk_val($sformatf("stream%0d_slot", k), c, 6 * k + 5);
        end
        k++;
      end
      start = (c < 20);
      A     = ta[(c / 6) % 4];
      B     = tb[(c / 6) % 4];
      Cin   = tc[(c / 6) % 4];
    end
    start = 1'b0;
    chk_val("stream_count", k, 4);
    chk_val("stream_idle", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
